muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Parametrised, iterative RISC-V M-extension unit sitting beside the integer ALU in EX.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on XLEN-bit operands using radix-2 shift-add (multiply) and restoring shift-subtract (divide).
- Valid/ready handshakes on input and output; flush input for pipeline squash.
- Stalls the pipeline via in_ready/out_valid while a long operation is in flight.

Parameters:
- XLEN, 32, operand/result width (>=8, power of two).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  in  XLEN  operand A (dividend / multiplicand).
- rs2_data  in  XLEN  operand B (divisor / multiplier).
- flush  in  1  abort current operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  result, held stable while out_valid && !out_ready.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (async, any state): state=IDLE, result=0, out_valid=0, busy=0, counter=0, internal registers=0. in_ready=1 after reset deasserts.
- States:
  - IDLE: accept on in_valid && in_ready && !flush. Latch op, operand signs, |A|, |B| (signed ops only; unsigned taken raw; MULHSU: A signed, B unsigned). Next state CALC with counter=XLEN, or DONE for special cases.
  - CALC: one iteration per edge; counter decrements; on the edge where counter reaches 0, register the sign-corrected result and go to DONE.
  - DONE: out_valid=1. out_valid && out_ready → IDLE. No new accept in DONE.
- Latency:
  - Normal operations: out_valid rises exactly XLEN+1 edges after the accept edge.
  - Special cases: out_valid high the cycle after accept.
- Multiply: 2*XLEN-bit unsigned product of magnitudes, negated if sign(A)^sign(B) (signed ops only). MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
- Divide: unsigned quotient/remainder of magnitudes. Quotient negated if signs differ; remainder takes the dividend's sign.
- Special cases (resolved at accept):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = rs1_data.
  - Signed overflow (A = most-negative, B = -1): DIV = A, REM = 0.
- flush:
  - In CALC or DONE: next state IDLE, out_valid=0, result retains old value, discarded op never produces out_valid.
  - flush in IDLE blocks acceptance that cycle.
  - flush has priority over in_valid and out_ready.
- Simultaneous out handshake and in_valid: the output completes; the new op is not accepted until the next cycle (in_ready=0 in DONE).
- Mid-operation reset: same as reset above; no partial result is ever emitted.

Optional Feature:
- Macro MULDIV_FASTMUL_EN.
- Defined: multiplies use a single combinational XLEN×XLEN multiplier. Result is registered at the accept edge and the unit goes IDLE→DONE, so out_valid is high the next cycle. Divides remain iterative.
- Undefined: multiplies iterate, XLEN+1-edge latency; no hardware multiplier inferred.

Decomposition:
- Shared package muldiv_pkg:
  - op encoding localparams (OP_MUL…OP_REMU).
  - state encoding (S_IDLE, S_CALC, S_DONE).
  - helper function for two's-complement magnitude.
- One natural sub-module: muldiv_sign_fix. Combinational input magnitude/sign extraction and output negation/selection, shared by the multiply and divide paths.
- Iteration datapath and FSM stay in muldiv_unit.

Test Plan:
- MUL 7 × 0xFFFFFFFD (XLEN=32) → result 0xFFFFFFEB. out_valid exactly 33 edges after accept (1 edge with MULDIV_FASTMUL_EN).
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 0xFFFFFFFF/16 → 0x0FFFFFFF. REMU 100/7 → 2.
- Special cases, each with out_valid the cycle after accept:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Backpressure and flush:
  - Hold out_ready=0 for 5 cycles in DONE → result and out_valid stable, in_ready=0.
  - Flush at CALC cycle 10 → IDLE next edge, in_ready=1, no out_valid for that op.
  - A following MUL 3×4 → 12.
- Assert rst at CALC cycle 5 → out_valid=0, result=0, in_ready=1 immediately (async). A subsequent DIVU 9/3 → 3.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the M-extension multiply/divide unit.
// Helpers work on MAX_W-bit values, so XLEN may be at most 64.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int MAX_W = 128;

    // Two's-complement negate when neg is set; the low bits of the result are
    // correct for any narrower zero-extended operand.
    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v, input logic neg);
        return neg ? (~v + MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude/sign extraction at accept, and sign correction plus
// result selection of the raw {hi, lo} iteration outcome.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] a_mag,
    output logic [XLEN-1:0] b_mag,
    output logic            a_neg,
    output logic            b_neg,
    input  logic [2:0]      fix_op,
    input  logic            fix_a_neg,
    input  logic            fix_b_neg,
    input  logic [XLEN-1:0] fix_hi,
    input  logic [XLEN-1:0] fix_lo,
    output logic [XLEN-1:0] fixed
);

    logic            a_signed;
    logic            b_signed;
    logic [2*XLEN-1:0] prod;

    // MUL low half is sign-agnostic, so it is handled as unsigned.
    assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign a_neg    = a_signed & rs1_data[XLEN-1];
    assign b_neg    = b_signed & rs2_data[XLEN-1];
    assign a_mag    = XLEN'(cond_neg(MAX_W'(rs1_data), a_neg));
    assign b_mag    = XLEN'(cond_neg(MAX_W'(rs2_data), b_neg));

    always_comb begin
        prod = (2*XLEN)'(cond_neg(MAX_W'({fix_hi, fix_lo}), fix_a_neg ^ fix_b_neg));
        case (fix_op)
            OP_MUL:                       fixed = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fixed = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fixed = XLEN'(cond_neg(MAX_W'(fix_lo), fix_a_neg ^ fix_b_neg));
            default:                      fixed = XLEN'(cond_neg(MAX_W'(fix_hi), fix_a_neg));
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit (shift-add / restoring divide).
// Define MULDIV_FASTMUL_EN for a single-cycle combinational multiply path.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    state_t            state, state_next;
    logic [2:0]        op_q;
    logic              a_neg_q, b_neg_q;
    logic [XLEN-1:0]   hi_q, lo_q, opnd_q, result_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [XLEN-1:0]   a_mag, b_mag, fixed, special_res;
    logic              a_neg, b_neg, accept, div_zero, div_ovf, special, fast;
    logic [2:0]        fix_op;
    logic              fix_a_neg, fix_b_neg;
    logic [XLEN-1:0]   fix_hi, fix_lo;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;

    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .op        (op),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .fix_op    (fix_op),
        .fix_a_neg (fix_a_neg),
        .fix_b_neg (fix_b_neg),
        .fix_hi    (fix_hi),
        .fix_lo    (fix_lo),
        .fixed     (fixed)
    );

    assign accept   = in_valid && in_ready && !flush;
    assign div_zero = op[2] && (rs2_data == '0);
    assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                      (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    assign special  = div_zero || div_ovf;
    // op[1] separates REM/REMU from DIV/DIVU.
    assign special_res = div_zero ? (op[1] ? rs1_data : '1) : (op[1] ? '0 : rs1_data);

`ifdef MULDIV_FASTMUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = (2*XLEN)'(a_mag) * (2*XLEN)'(b_mag);
    assign fast      = ~op[2];
    // In IDLE the fix-up stage corrects the combinational product of the incoming op.
    always_comb begin
        if (state == S_IDLE) begin
            fix_op    = op;
            fix_a_neg = a_neg;
            fix_b_neg = b_neg;
            fix_hi    = fast_prod[2*XLEN-1:XLEN];
            fix_lo    = fast_prod[XLEN-1:0];
        end else begin
            fix_op    = op_q;
            fix_a_neg = a_neg_q;
            fix_b_neg = b_neg_q;
            fix_hi    = hi_q;
            fix_lo    = lo_q;
        end
    end
`else
    assign fast      = 1'b0;
    assign fix_op    = op_q;
    assign fix_a_neg = a_neg_q;
    assign fix_b_neg = b_neg_q;
    assign fix_hi    = hi_q;
    assign fix_lo    = lo_q;
`endif

    assign mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = (special || fast) ? S_DONE : S_CALC;
            S_CALC: if (flush) state_next = S_IDLE;
                    else if (cnt_q == '0) state_next = S_DONE;
            S_DONE: if (flush || out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        busy      = (state != S_IDLE);
    end

    // Multiply: hi:lo is partial product : multiplier. Divide: hi:lo is remainder : dividend/quotient.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    op_q    <= op;
                    a_neg_q <= a_neg;
                    b_neg_q <= b_neg;
                    cnt_q   <= CNT_W'(XLEN);
                    hi_q    <= '0;
                    lo_q    <= op[2] ? a_mag : b_mag;
                    opnd_q  <= op[2] ? b_mag : a_mag;
                    if (special)   result_q <= special_res;
                    else if (fast) result_q <= fixed;
                end
                S_CALC: if (!flush) begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (!op_q[2]) begin
                            hi_q <= mul_sum[XLEN:1];
                            lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
                        end else if (div_diff[XLEN]) begin
                            hi_q <= div_shift[XLEN-1:0];
                            lo_q <= {lo_q[XLEN-2:0], 1'b0};
                        end else begin
                            hi_q <= div_diff[XLEN-1:0];
                            lo_q <= {lo_q[XLEN-2:0], 1'b1};
                        end
                    end else begin
                        result_q <= fixed;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;

endmodule
